oled_write_arbiter: RTL and testbench

- Shares the single 9-bit OLED SPI word serializer among two requesters.
  - Requester 0: init/command sequencer.
  - Requester 1: pixel/text renderer.
- Each word is {DC, byte[7:0]}; DC=0 means command, DC=1 means data.
- Arbitrates per burst with round-robin fairness, issues one word at a time to the serializer, and enforces a programmable inter-word gap.
- Sits between the display sequencing logic and the SPI shift engine, in the 1 MHz OLED clock domain.

---
 rtl/oled_write_arbiter.sv | 95 +++++++++
 tb/tb_oled_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_write_arbiter.sv
// oled_write_arbiter: round-robin burst arbiter sharing the OLED SPI word serializer
// between the init sequencer (req0) and the renderer (req1), with a programmable inter-word gap.
module oled_write_arbiter #(
  parameter int GAP_CYCLES = 6,
  parameter int GAP_W = 16
) (
  input  logic       clk_in_1MHz,
  input  logic       rst_n_in,
  input  logic       req0_valid,
  input  logic [8:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [8:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       ser_start,
  output logic [8:0] ser_data,
  input  logic       ser_done,
  output logic [1:0] grant,
  output logic       busy
);
  localparam logic [2:0] IDLE = 3'd0, ARB = 3'd1, ISSUE = 3'd2, WAIT_DONE = 3'd3, GAP = 3'd4;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  logic [2:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic rr_ptr_q, rr_ptr_d, last_q, last_d;
  logic [8:0] ser_data_q, ser_data_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic lock, sel, sel_valid, post_gap;
  always_comb begin
    lock = |grant_q;
    // A locked burst only ever looks at its owner; no preemption
    sel = lock ? grant_q[1] : (req1_valid && (!req0_valid || rr_ptr_q));
    sel_valid = lock ? (grant_q[1] ? req1_valid : req0_valid) : (req0_valid || req1_valid);
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    last_d = last_q;
    ser_data_d = ser_data_q;
    gap_cnt_d = gap_cnt_q;
    post_gap = 1'b0;
    case (state_q)
      IDLE: state_d = (req0_valid || req1_valid) ? ARB : IDLE;
      ARB:
        if (sel_valid) begin
          state_d = ISSUE;
          grant_d = sel ? 2'b10 : 2'b01;
          ser_data_d = sel ? req1_data : req0_data;
          last_d = sel ? req1_last : req0_last;
        end else if (!lock) state_d = IDLE;
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE:
        if (ser_done) begin
          state_d = GAP;
          gap_cnt_d = '0;
          post_gap = (GAP_CYCLES == 0);
        end
      GAP: begin
        post_gap = (gap_cnt_q == GAP_LAST);
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (post_gap) begin
      state_d = ARB;
      if (last_q) begin
        grant_d = 2'b00;
        rr_ptr_d = ~grant_q[1];
      end
    end
  end
  always_ff @(posedge clk_in_1MHz or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rr_ptr_q <= 1'b0;
      last_q <= 1'b0;
      ser_data_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      last_q <= last_d;
      ser_data_q <= ser_data_d;
      gap_cnt_q <= gap_cnt_d;
    end
  assign ser_start = (state_q == ISSUE);
  assign req0_ready = ser_start & grant_q[0];
  assign req1_ready = ser_start & grant_q[1];
  assign ser_data = ser_data_q;
  assign grant = grant_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_oled_write_arbiter.sv
// tb_oled_write_arbiter: scoreboard bench; requester drivers and a serializer model run
// alongside the scenario tasks, and a monitor pops expected words on every ser_start.
module tb_oled_write_arbiter;
  localparam int SER_LAT = 18;
  logic clk_in_1MHz = 1'b0;
  logic rst_n_in = 1'b0;
  logic req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
  logic [8:0] req0_data, req1_data, ser_data;
  logic ser_start, ser_done, busy;
  logic [1:0] grant;
  logic z_valid = 1'b0, z_last = 1'b0, z_done = 1'b0, z_zero = 1'b0;
  logic [8:0] z_data = 9'h0, z_zdata = 9'h0, z_sdata;
  logic z_ready0, z_ready1, z_start, z_busy;
  logic [1:0] z_grant;
  logic [9:0] src0[$], src1[$], exp_q[$];
  int st_hist[$], dn_hist[$];
  int cyc = 0, n_cmp = 0, n_fail = 0, stray = 0, v0_rise = -100, ser_cnt = 0;

  oled_write_arbiter u_dut (
    .clk_in_1MHz(clk_in_1MHz), .rst_n_in(rst_n_in),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .ser_start(ser_start), .ser_data(ser_data), .ser_done(ser_done), .grant(grant), .busy(busy)
  );
  oled_write_arbiter #(.GAP_CYCLES(0)) u_gap0 (
    .clk_in_1MHz(clk_in_1MHz), .rst_n_in(rst_n_in),
    .req0_valid(z_valid), .req0_data(z_data), .req0_last(z_last), .req0_ready(z_ready0),
    .req1_valid(z_zero), .req1_data(z_zdata), .req1_last(z_zero), .req1_ready(z_ready1),
    .ser_start(z_start), .ser_data(z_sdata), .ser_done(z_done), .grant(z_grant), .busy(z_busy)
  );

  always #5 clk_in_1MHz = ~clk_in_1MHz;
  always @(posedge clk_in_1MHz) cyc <= cyc + 1;

  // Requester drivers: present queue heads, advance on the ready pulse
  initial begin
    logic prev0;
    prev0 = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    forever begin
      @(negedge clk_in_1MHz);
      if (rst_n_in && req0_ready && src0.size() > 0) void'(src0.pop_front());
      if (rst_n_in && req1_ready && src1.size() > 0) void'(src1.pop_front());
      req0_valid = src0.size() > 0;
      req0_data = req0_valid ? src0[0][8:0] : 9'h0;
      req0_last = req0_valid ? src0[0][9] : 1'b0;
      req1_valid = src1.size() > 0;
      req1_data = req1_valid ? src1[0][8:0] : 9'h0;
      req1_last = req1_valid ? src1[0][9] : 1'b0;
      if (req0_valid && !prev0) v0_rise = cyc;
      prev0 = req0_valid;
    end
  end

  // Serializer model: ser_done pulse SER_LAT cycles after each start
  initial begin
    ser_done = 1'b0;
    forever begin
      @(negedge clk_in_1MHz);
      ser_done = 1'b0;
      if (!rst_n_in) ser_cnt = 0;
      else begin
        if (ser_cnt > 0) begin
          ser_cnt--;
          if (ser_cnt == 0) begin
            ser_done = 1'b1;
            dn_hist.push_back(cyc);
          end
        end
        if (ser_start) ser_cnt = SER_LAT;
      end
    end
  end

  // Monitor: every issued word is checked against the scoreboard head
  initial begin
    logic [9:0] e;
    logic [12:0] want, got;
    forever begin
      @(negedge clk_in_1MHz);
      if (rst_n_in) begin
        if ((req0_ready || req1_ready) && !ser_start) stray++;
        if (ser_start) begin
          st_hist.push_back(cyc);
          got = {grant, req1_ready, req0_ready, ser_data};
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got grant/ready/data %b %b%b %h, wanted no issue", grant, req1_ready, req0_ready, ser_data);
          end else begin
            e = exp_q.pop_front();
            want = {e[9] ? 2'b10 : 2'b01, e[9], ~e[9], e[8:0]};
            if (got !== want) begin
              n_fail++;
              $display("FAIL issue_word: got grant/ready/data %b %b%b %h, wanted %b %b%b %h",
                       got[12:11], got[10], got[9], got[8:0], want[12:11], want[10], want[9], want[8:0]);
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in_1MHz);
      if (!busy && src0.size() == 0 && src1.size() == 0 && !req0_valid && !req1_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in_1MHz);
    outs = {ser_start, req0_ready, req1_ready, ser_data, grant, busy};
    n_cmp++;
    if (outs !== 15'h0) begin n_fail++; $display("FAIL reset_outputs: got %h, wanted 0", outs); end
    rst_n_in = 1'b1;
    repeat (3) @(negedge clk_in_1MHz);
    n_cmp++;
    if ({busy, grant} !== 3'b000) begin n_fail++; $display("FAIL reset_idle: got busy/grant %b%b, wanted 000", busy, grant); end
  endtask

  task automatic test_contention();
    bit ok;
    exp_q.push_back({1'b0, 9'h0B0}); exp_q.push_back({1'b1, 9'h154});
    src0.push_back({1'b1, 9'h0B0}); src1.push_back({1'b1, 9'h154});
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL contention_timeout: idle %0d, wanted 1", ok); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL contention_drain: %0d words left, wanted 0", exp_q.size()); end
  endtask

  task automatic test_burst_lock();
    bit ok;
    int n0, bad;
    bad = 0;
    n0 = st_hist.size();
    exp_q.push_back({1'b0, 9'h0B0}); exp_q.push_back({1'b0, 9'h010});
    exp_q.push_back({1'b0, 9'h001}); exp_q.push_back({1'b1, 9'h178});
    src0.push_back({1'b0, 9'h0B0}); src0.push_back({1'b0, 9'h010}); src0.push_back({1'b1, 9'h001});
    src1.push_back({1'b1, 9'h178});
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in_1MHz);
      if (st_hist.size() >= n0 + 3) break;
      if (st_hist.size() >= n0 + 1 && grant !== 2'b01) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL burst_grant: %0d cycles with grant off 01, wanted 0", bad); end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL burst_timeout: idle %0d, wanted 1", ok); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL burst_drain: %0d words left, wanted 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, 9'(9'h0C0 + k)}); exp_q.push_back({1'b1, 9'(9'h1D0 + k)});
      src0.push_back({1'b1, 9'(9'h0C0 + k)}); src1.push_back({1'b1, 9'(9'h1D0 + k)});
    end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL rr_timeout: idle %0d, wanted 1", ok); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_drain: %0d words left, wanted 0", exp_q.size()); end
  endtask

  task automatic test_single();
    bit ok;
    int lat, idle_dly;
    st_hist.delete(); dn_hist.delete();
    exp_q.push_back({1'b0, 9'h0AE});
    src0.push_back({1'b1, 9'h0AE});
    wait_idle(ok);
    lat = st_hist.size() > 0 ? st_hist[0] - v0_rise : -1;
    idle_dly = dn_hist.size() > 0 ? cyc - dn_hist[0] : -1;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: idle %0d, wanted 1", ok); end
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d cycles, wanted 2", lat); end
    n_cmp++;
    if (idle_dly != 8) begin n_fail++; $display("FAIL single_gap_to_idle: got %0d cycles, wanted 8", idle_dly); end
    n_cmp++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL single_grant_release: got %b, wanted 00", grant); end
  endtask

  task automatic test_gap();
    bit ok;
    int d, t, gap6;
    st_hist.delete(); dn_hist.delete();
    exp_q.push_back({1'b0, 9'h0B0}); exp_q.push_back({1'b0, 9'h010});
    src0.push_back({1'b0, 9'h0B0}); src0.push_back({1'b1, 9'h010});
    wait_idle(ok);
    gap6 = (st_hist.size() > 1 && dn_hist.size() > 0) ? st_hist[1] - dn_hist[0] : -1;
    n_cmp++;
    if (gap6 != 8) begin n_fail++; $display("FAIL gap6_spacing: got %0d cycles, wanted 8", gap6); end
    z_data = 9'h1A5; z_last = 1'b1; z_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in_1MHz);
      if (z_start) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || z_sdata !== 9'h1A5) begin n_fail++; $display("FAIL gap0_first: got start %0d data %h, wanted 1 1a5", ok, z_sdata); end
    repeat (3) @(negedge clk_in_1MHz);
    z_done = 1'b1;
    d = cyc;
    @(negedge clk_in_1MHz);
    z_done = 1'b0;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      if (z_start) begin t = cyc; break; end
      @(negedge clk_in_1MHz);
    end
    n_cmp++;
    if (t - d != 2) begin n_fail++; $display("FAIL gap0_spacing: got %0d cycles, wanted 2", t - d); end
    z_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [14:0] outs;
    exp_q.push_back({1'b0, 9'h0A5});
    src0.push_back({1'b1, 9'h0A5});
    wait_idle(ok);
    exp_q.push_back({1'b0, 9'h011});
    src0.push_back({1'b0, 9'h011}); src0.push_back({1'b1, 9'h022});
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_in_1MHz);
    repeat (4) @(negedge clk_in_1MHz);
    #2 rst_n_in = 1'b0;
    #1 outs = {ser_start, req0_ready, req1_ready, ser_data, grant, busy};
    n_cmp++;
    if (outs !== 15'h0) begin n_fail++; $display("FAIL midreset_outputs: got %h, wanted 0", outs); end
    src0.delete(); src1.delete(); exp_q.delete();
    repeat (3) @(negedge clk_in_1MHz);
    rst_n_in = 1'b1;
    exp_q.push_back({1'b0, 9'h0C1}); exp_q.push_back({1'b1, 9'h1C2});
    src0.push_back({1'b1, 9'h0C1}); src1.push_back({1'b1, 9'h1C2});
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL midreset_timeout: idle %0d, wanted 1", ok); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_drain: %0d words left, wanted 0", exp_q.size()); end
    n_cmp++;
    if (stray != 0) begin n_fail++; $display("FAIL stray_ready: got %0d pulses, wanted 0", stray); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_burst_lock();
    test_round_robin();
    test_single();
    test_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
